ahb_lite_master_pipe: RTL and testbench

Parametrised, pipelined AHB-Lite bus master. It replaces the single-transfer "Junior" master. A simple valid/ready command port accepts reads and writes and issues them as AHB-Lite transfers, with the address phase of transfer N+1 overlapping the data phase of transfer N. It handles wait states and the two-cycle ERROR response, and returns one response per command on a registered response port. The block sits between a local requester (CPU/DMA stub) and the AHB-Lite interconnect.

---
 rtl/ahb_lite_master_pipe_if.sv | 44 ++++
 rtl/ahb_lite_master_pipe.sv | 172 +++++++++++++++++
 tb/tb_ahb_lite_master_pipe.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_lite_master_pipe_if.sv
// Command/response port plus AHB-Lite master signals for ahb_lite_master_pipe.
// The master modport is the bus master; the slave modport is the requester plus interconnect side.
interface ahb_lite_master_pipe_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [2:0]        cmd_size;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic              rsp_write;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  logic [ADDR_W-1:0] HADDR;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [1:0]        HTRANS;
  logic [2:0]        HBURST;
  logic [DATA_W-1:0] HWDATA;
  logic [DATA_W-1:0] HRDATA;
  logic              HREADY;
  logic              HRESP;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_write, rsp_rdata, rsp_err,
    output HADDR, HWRITE, HSIZE, HTRANS, HBURST, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_write, rsp_rdata, rsp_err,
    input  HADDR, HWRITE, HSIZE, HTRANS, HBURST, HWDATA,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/ahb_lite_master_pipe.sv
// Pipelined AHB-Lite master: valid/ready commands in, one registered response per command out.
// Define AHB_MASTER_INCR_BURST_EN to issue contiguous commands as SEQ beats of an INCR burst.
module ahb_lite_master_pipe #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_SIZE = $clog2(DATA_W / 8)
) (
  input logic                    HCLK,
  input logic                    HRESETn,
  ahb_lite_master_pipe_if.master bus
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  // State is the occupancy of the address (A) and data (D) slots, plus the second error cycle.
  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_PIPE,
    S_DATA,
    S_ERR2
  } state_t;

  state_t            state, state_next;
  logic              held_q;
  logic              d_write_q;
  logic [DATA_W-1:0] a_wdata_q;

  logic              a_valid;
  logic              err_first;
  logic              accept;
  logic              a_to_d;
  logic              d_done;
  logic              reissue;
  logic              next_a;
  logic [2:0]        size_c;
  logic [1:0]        trans_new;
  logic [2:0]        burst_new;

  assign a_valid   = (state == S_ADDR) || (state == S_PIPE);
  assign err_first = ((state == S_PIPE) || (state == S_DATA)) && bus.HRESP && !bus.HREADY;
  assign next_a    = (state_next == S_ADDR) || (state_next == S_PIPE);

  assign bus.cmd_ready = HRESETn && (state != S_ERR2) && !err_first && (!a_valid || bus.HREADY);
  assign accept        = bus.cmd_valid && bus.cmd_ready;

  assign size_c = (bus.cmd_size > 3'(MAX_SIZE)) ? 3'(MAX_SIZE) : bus.cmd_size;

`ifdef AHB_MASTER_INCR_BURST_EN
  logic seq_ok;

  // Continues the burst only when the new beat directly follows a live address phase.
  assign seq_ok = a_valid
               && (bus.cmd_write == bus.HWRITE)
               && (size_c == bus.HSIZE)
               && (bus.cmd_addr == bus.HADDR + (ADDR_W'(1) << bus.HSIZE))
               && (bus.cmd_addr[ADDR_W-1:10] == bus.HADDR[ADDR_W-1:10]);
  assign trans_new = seq_ok ? 2'b11 : HTRANS_NONSEQ;
  assign burst_new = 3'b001;
`else
  assign trans_new = HTRANS_NONSEQ;
  assign burst_new = HBURST_SINGLE;
`endif

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_next = state;
    a_to_d     = 1'b0;
    d_done     = 1'b0;
    reissue    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (accept) state_next = S_ADDR;
      end
      S_ADDR: begin
        if (bus.HREADY) begin
          a_to_d     = 1'b1;
          state_next = accept ? S_PIPE : S_DATA;
        end
      end
      S_PIPE: begin
        if (bus.HREADY) begin
          d_done     = 1'b1;
          a_to_d     = 1'b1;
          state_next = accept ? S_PIPE : S_DATA;
        end else if (bus.HRESP) begin
          state_next = S_ERR2;
        end
      end
      S_DATA: begin
        if (bus.HREADY) begin
          d_done     = 1'b1;
          state_next = accept ? S_ADDR : S_IDLE;
        end else if (bus.HRESP) begin
          state_next = S_ERR2;
        end
      end
      S_ERR2: begin
        if (bus.HREADY) begin
          d_done     = 1'b1;
          reissue    = held_q;
          state_next = held_q ? S_ADDR : S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state  <= S_IDLE;
      held_q <= 1'b0;
    end else begin
      state <= state_next;
      // Remember whether the error cancelled a live address phase that must be reissued.
      if (state_next == S_ERR2) held_q <= (state == S_ERR2) ? held_q : a_valid;
      else                      held_q <= 1'b0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      bus.HADDR  <= '0;
      bus.HWRITE <= 1'b0;
      bus.HSIZE  <= 3'b000;
      bus.HTRANS <= HTRANS_IDLE;
      bus.HBURST <= HBURST_SINGLE;
      bus.HWDATA <= '0;
      a_wdata_q  <= '0;
      d_write_q  <= 1'b0;
    end else begin
      if (accept) begin
        bus.HADDR  <= bus.cmd_addr;
        bus.HWRITE <= bus.cmd_write;
        bus.HSIZE  <= size_c;
        bus.HTRANS <= trans_new;
        bus.HBURST <= burst_new;
        a_wdata_q  <= bus.cmd_wdata;
      end else if (reissue) begin
        bus.HTRANS <= HTRANS_NONSEQ;
      end else if (!next_a) begin
        bus.HTRANS <= HTRANS_IDLE;
      end

      // Write data enters HWDATA as the command leaves the address phase.
      if (a_to_d) begin
        d_write_q <= bus.HWRITE;
        if (bus.HWRITE) bus.HWDATA <= a_wdata_q;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_write <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      bus.rsp_valid <= d_done;
      if (d_done) begin
        bus.rsp_write <= d_write_q;
        bus.rsp_rdata <= d_write_q ? '0 : bus.HRDATA;
        bus.rsp_err   <= bus.HRESP;
      end
    end
  end

endmodule

// File: tb/tb_ahb_lite_master_pipe.sv
// Directed bench for ahb_lite_master_pipe: cycle-exact AHB checks in the main flow,
// responses checked by a scoreboard monitor against expectations queued at issue time.
`timescale 1ns/1ps
module tb_ahb_lite_master_pipe;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

`ifdef AHB_MASTER_INCR_BURST_EN
  localparam logic [2:0] EXP_HBURST = 3'b001;
`else
  localparam logic [2:0] EXP_HBURST = 3'b000;
`endif

  typedef struct {
    logic              write;
    logic [DATA_W-1:0] rdata;
    logic              err;
  } rsp_t;

  logic HCLK;
  logic HRESETn;
  int   checks   = 0;
  int   failures = 0;
  rsp_t sb[$];

  ahb_lite_master_pipe_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ahb_lite_master_pipe #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus.master)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic cmd(input logic w, input logic [ADDR_W-1:0] a, input logic [2:0] s,
                     input logic [DATA_W-1:0] d);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_size  = s;
    bus.cmd_wdata = d;
  endtask

  task automatic no_cmd();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic expect_rsp(input logic w, input logic [DATA_W-1:0] d, input logic e);
    rsp_t r;
    r.write = w;
    r.rdata = d;
    r.err   = e;
    sb.push_back(r);
  endtask

  // Response monitor: every rsp_valid pulse must match the oldest queued expectation.
  always @(negedge HCLK) begin
    if (HRESETn && bus.rsp_valid) begin
      check("rsp_expected_pending", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        rsp_t e;
        e = sb.pop_front();
        check("rsp_write", 64'(bus.rsp_write), 64'(e.write));
        check("rsp_rdata", 64'(bus.rsp_rdata), 64'(e.rdata));
        check("rsp_err",   64'(bus.rsp_err),   64'(e.err));
      end
    end
  end

  initial begin
    logic [1:0] exp_tr[4];
`ifdef AHB_MASTER_INCR_BURST_EN
    exp_tr = '{2'b10, 2'b11, 2'b10, 2'b11};
`else
    exp_tr = '{2'b10, 2'b10, 2'b10, 2'b10};
`endif

    HRESETn       = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_size  = 3'd0;
    bus.cmd_wdata = '0;
    bus.HRDATA    = '0;
    bus.HREADY    = 1'b1;
    bus.HRESP     = 1'b0;

    // Reset values
    #2;
    check("rst_htrans",    64'(bus.HTRANS),    64'h0);
    check("rst_haddr",     64'(bus.HADDR),     64'h0);
    check("rst_hwrite",    64'(bus.HWRITE),    64'h0);
    check("rst_hsize",     64'(bus.HSIZE),     64'h0);
    check("rst_hburst",    64'(bus.HBURST),    64'h0);
    check("rst_hwdata",    64'(bus.HWDATA),    64'h0);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
    check("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'h0);
    check("rst_rsp_err",   64'(bus.rsp_err),   64'h0);
    check("rst_cmd_ready", 64'(bus.cmd_ready), 64'h0);
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    tick();

    // Single read, zero waits: address phase cycle 1, data cycle 2, response cycle 3
    cmd(1'b0, 32'h100, 3'd2, '0);
    #1;
    check("rd_cmd_ready", 64'(bus.cmd_ready), 64'h1);
    expect_rsp(1'b0, 32'hDEADBEEF, 1'b0);
    tick();
    no_cmd();
    check("rd_htrans_c1", 64'(bus.HTRANS), 64'h2);
    check("rd_haddr_c1",  64'(bus.HADDR),  64'h100);
    check("rd_hwrite_c1", 64'(bus.HWRITE), 64'h0);
    check("rd_hsize_c1",  64'(bus.HSIZE),  64'h2);
    check("rd_hburst_c1", 64'(bus.HBURST), 64'(EXP_HBURST));
    tick();
    bus.HRDATA = 32'hDEADBEEF;
    check("rd_htrans_c2",    64'(bus.HTRANS),    64'h0);
    check("rd_rsp_valid_c2", 64'(bus.rsp_valid), 64'h0);
    tick();
    bus.HRDATA = '0;
    check("rd_rsp_valid_c3", 64'(bus.rsp_valid), 64'h1);
    repeat (2) tick();

    // Write 0x200 then read 0x204 back-to-back, zero waits
    cmd(1'b1, 32'h200, 3'd2, 32'h11111111);
    expect_rsp(1'b1, '0, 1'b0);
    tick();
    check("wr_haddr_c1",  64'(bus.HADDR),  64'h200);
    check("wr_hwrite_c1", 64'(bus.HWRITE), 64'h1);
    cmd(1'b0, 32'h204, 3'd2, '0);
    #1;
    check("b2b_cmd_ready", 64'(bus.cmd_ready), 64'h1);
    expect_rsp(1'b0, 32'hCAFE0204, 1'b0);
    tick();
    no_cmd();
    check("b2b_haddr",  64'(bus.HADDR),  64'h204);
    check("b2b_hwdata", 64'(bus.HWDATA), 64'h11111111);
    check("b2b_htrans", 64'(bus.HTRANS), 64'h2);
    tick();
    bus.HRDATA = 32'hCAFE0204;
    check("b2b_wr_rsp_valid", 64'(bus.rsp_valid), 64'h1);
    tick();
    bus.HRDATA = '0;
    repeat (2) tick();

    // Two wait states on the write data phase
    cmd(1'b1, 32'h200, 3'd2, 32'h22222222);
    expect_rsp(1'b1, '0, 1'b0);
    tick();
    cmd(1'b0, 32'h204, 3'd2, '0);
    expect_rsp(1'b0, 32'h5A5A5A5A, 1'b0);
    tick();
    no_cmd();
    for (int w = 0; w < 3; w++) begin
      bus.HREADY = (w == 2);
      #1;
      check("ws_haddr",  64'(bus.HADDR),  64'h204);
      check("ws_hwdata", 64'(bus.HWDATA), 64'h22222222);
      check("ws_htrans", 64'(bus.HTRANS), 64'h2);
      if (w < 2) check("ws_cmd_ready", 64'(bus.cmd_ready), 64'h0);
      tick();
    end
    bus.HREADY = 1'b1;
    bus.HRDATA = 32'h5A5A5A5A;
    check("ws_wr_rsp_valid", 64'(bus.rsp_valid), 64'h1);
    tick();
    bus.HRDATA = '0;
    repeat (2) tick();

    // ERROR on the write while the read sits in the address phase
    cmd(1'b1, 32'h200, 3'd2, 32'h33333333);
    expect_rsp(1'b1, '0, 1'b1);
    tick();
    cmd(1'b0, 32'h204, 3'd2, '0);
    expect_rsp(1'b0, 32'h0BADF00D, 1'b0);
    tick();
    no_cmd();
    bus.HREADY = 1'b0;
    bus.HRESP  = 1'b1;
    #1;
    check("err1_cmd_ready", 64'(bus.cmd_ready), 64'h0);
    tick();
    bus.HREADY = 1'b1;
    #1;
    check("err2_htrans",    64'(bus.HTRANS),    64'h0);
    check("err2_cmd_ready", 64'(bus.cmd_ready), 64'h0);
    tick();
    bus.HRESP = 1'b0;
    check("reissue_htrans", 64'(bus.HTRANS),    64'h2);
    check("reissue_haddr",  64'(bus.HADDR),     64'h204);
    check("reissue_hwrite", 64'(bus.HWRITE),    64'h0);
    check("err_rsp_valid",  64'(bus.rsp_valid), 64'h1);
    tick();
    bus.HRDATA = 32'h0BADF00D;
    check("reissue_data_htrans", 64'(bus.HTRANS), 64'h0);
    tick();
    bus.HRDATA = '0;
    repeat (2) tick();

    // Four contiguous reads across the 1 KB boundary at 0x400
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        cmd(1'b0, 32'h3F8 + 32'(4 * i), 3'd2, '0);
        expect_rsp(1'b0, 32'hA00003F8 + 32'(4 * i), 1'b0);
      end else begin
        no_cmd();
      end
      bus.HRDATA = (i >= 2) ? 32'hA00003F8 + 32'(4 * (i - 2)) : '0;
      if (i >= 1 && i <= 4) begin
        check("burst_htrans", 64'(bus.HTRANS), 64'(exp_tr[i-1]));
        check("burst_haddr",  64'(bus.HADDR),  64'h3F8 + 64'(4 * (i - 1)));
        check("burst_hburst", 64'(bus.HBURST), 64'(EXP_HBURST));
      end
      tick();
    end
    bus.HRDATA = '0;
    repeat (2) tick();

    // Oversized, misaligned write: HSIZE clamps to 2, address passes through unchanged
    cmd(1'b1, 32'h501, 3'd3, 32'h44444444);
    expect_rsp(1'b1, '0, 1'b0);
    tick();
    no_cmd();
    check("clamp_hsize", 64'(bus.HSIZE), 64'h2);
    check("clamp_haddr", 64'(bus.HADDR), 64'h501);
    tick();
    check("clamp_hwdata", 64'(bus.HWDATA), 64'h44444444);
    repeat (3) tick();

    // Asynchronous reset while the pipeline is full; nothing in flight may respond
    cmd(1'b1, 32'h600, 3'd2, 32'h55555555);
    tick();
    cmd(1'b0, 32'h604, 3'd2, '0);
    tick();
    cmd(1'b0, 32'h608, 3'd2, '0);
    tick();
    no_cmd();
    #2;
    HRESETn = 1'b0;
    sb.delete();
    #1;
    check("rst_mid_htrans",    64'(bus.HTRANS),    64'h0);
    check("rst_mid_rsp_valid", 64'(bus.rsp_valid), 64'h0);
    check("rst_mid_cmd_ready", 64'(bus.cmd_ready), 64'h0);
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    repeat (4) tick();
    check("post_rst_htrans", 64'(bus.HTRANS), 64'h0);

    check("sb_drained", 64'(sb.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
